// File: rtl/flash_fetch_ctrl_if.sv
// Fetch-stage request/response bundle for flash_fetch_ctrl.
interface flash_fetch_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_instr, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_instr, rsp_err
  );
endinterface

// File: rtl/flash_fetch_ctrl.sv
// Instruction fetch controller for a pair of 16-bit S29AL008J flash devices.
// Optional next-word prefetch buffer enabled by defining FETCH_PREFETCH_EN.
module flash_fetch_ctrl #(
  parameter int unsigned ACCESS_CYCLES = 7,
  parameter int unsigned RST_CYCLES    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  flash_fetch_ctrl_if.slave        bus,
  output logic                     flash_ce_n,
  output logic                     flash_oe_n,
  output logic                     flash_we_n,
  output logic                     flash_reset_n,
  output logic                     flash_byte,
  output logic [18:0]              flash_addr,
  input  logic [15:0]              flash_dq_upper,
  input  logic [15:0]              flash_dq_lower
);

  localparam int unsigned CNT_MAX = (ACCESS_CYCLES > RST_CYCLES) ? ACCESS_CYCLES : RST_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] ACC_LOAD = CNT_W'(ACCESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
`ifdef FETCH_PREFETCH_EN
    S_PF,
`endif
    S_FRST,
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_instr_q, rsp_instr_d;
  logic              rsp_err_q, rsp_err_d;
  logic              busy_q, busy_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              reset_n_q, reset_n_d;
  logic [18:0]       flash_addr_q, flash_addr_d;

`ifdef FETCH_PREFETCH_EN
  logic              buf_valid_q, buf_valid_d;
  logic [17:0]       buf_idx_q, buf_idx_d;
  logic [31:0]       buf_data_q, buf_data_d;
  logic [17:0]       cur_idx_q, cur_idx_d;
`endif

  logic        accept;
  logic        addr_err;
  logic [17:0] req_idx;

  assign accept   = bus.req_valid && req_ready_q;
  assign addr_err = (|bus.req_addr[1:0]) || (|bus.req_addr[31:20]);
  assign req_idx  = bus.req_addr[19:2];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_ready_d  = req_ready_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_instr_d  = rsp_instr_q;
    rsp_err_d    = rsp_err_q;
    busy_d       = busy_q;
    ce_n_d       = ce_n_q;
    oe_n_d       = oe_n_q;
    reset_n_d    = reset_n_q;
    flash_addr_d = flash_addr_q;
`ifdef FETCH_PREFETCH_EN
    buf_valid_d  = buf_valid_q;
    buf_idx_d    = buf_idx_q;
    buf_data_d   = buf_data_q;
    cur_idx_d    = cur_idx_q;
`endif

    case (state_q)
      S_FRST: begin
        if (cnt_q == '0) begin
          state_d     = S_IDLE;
          reset_n_d   = 1'b1;
          req_ready_d = 1'b1;
          busy_d      = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_IDLE: begin
        if (accept) begin
          req_ready_d = 1'b0;
          busy_d      = 1'b1;
          if (addr_err) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_instr_d = '0;
          end
`ifdef FETCH_PREFETCH_EN
          else if (buf_valid_q && (buf_idx_q == req_idx)) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_instr_d = buf_data_q;
          end
`endif
          else begin
            state_d      = S_ACCESS;
            flash_addr_d = {req_idx, 1'b0};
            ce_n_d       = 1'b0;
            oe_n_d       = 1'b0;
            cnt_d        = ACC_LOAD;
          end
`ifdef FETCH_PREFETCH_EN
          // Any good request consumes or discards the buffer; errors leave it alone.
          if (!addr_err) begin
            buf_valid_d = 1'b0;
            cur_idx_d   = req_idx;
          end
`endif
        end
      end

      S_ACCESS: begin
        if (cnt_q == '0) begin
          state_d     = S_RESP;
          rsp_instr_d = {flash_dq_upper, flash_dq_lower};
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          ce_n_d      = 1'b1;
          oe_n_d      = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
          req_ready_d = 1'b1;
          busy_d      = 1'b0;
`ifdef FETCH_PREFETCH_EN
          // No prefetch past the last word of the device.
          if (!rsp_err_q && (cur_idx_q != '1)) begin
            state_d      = S_PF;
            req_ready_d  = 1'b0;
            busy_d       = 1'b1;
            flash_addr_d = {18'(cur_idx_q + 18'd1), 1'b0};
            ce_n_d       = 1'b0;
            oe_n_d       = 1'b0;
            cnt_d        = ACC_LOAD;
          end
`endif
        end
      end

`ifdef FETCH_PREFETCH_EN
      S_PF: begin
        if (cnt_q == '0) begin
          buf_data_d  = {flash_dq_upper, flash_dq_lower};
          buf_idx_d   = flash_addr_q[18:1];
          buf_valid_d = 1'b1;
          ce_n_d      = 1'b1;
          oe_n_d      = 1'b1;
          state_d     = S_IDLE;
          req_ready_d = 1'b1;
          busy_d      = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`endif

      default: begin
        state_d   = S_FRST;
        reset_n_d = 1'b0;
        cnt_d     = RST_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FRST;
      cnt_q        <= RST_LOAD;
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_instr_q  <= '0;
      rsp_err_q    <= 1'b0;
      busy_q       <= 1'b1;
      ce_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      reset_n_q    <= 1'b0;
      flash_addr_q <= '0;
`ifdef FETCH_PREFETCH_EN
      buf_valid_q  <= 1'b0;
      buf_idx_q    <= '0;
      buf_data_q   <= '0;
      cur_idx_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_instr_q  <= rsp_instr_d;
      rsp_err_q    <= rsp_err_d;
      busy_q       <= busy_d;
      ce_n_q       <= ce_n_d;
      oe_n_q       <= oe_n_d;
      reset_n_q    <= reset_n_d;
      flash_addr_q <= flash_addr_d;
`ifdef FETCH_PREFETCH_EN
      buf_valid_q  <= buf_valid_d;
      buf_idx_q    <= buf_idx_d;
      buf_data_q   <= buf_data_d;
      cur_idx_q    <= cur_idx_d;
`endif
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_instr = rsp_instr_q;
  assign bus.rsp_err   = rsp_err_q;
  assign flash_ce_n    = ce_n_q;
  assign flash_oe_n    = oe_n_q;
  assign flash_we_n    = 1'b1;
  assign flash_byte    = 1'b1;
  assign flash_reset_n = reset_n_q;
  assign flash_addr    = flash_addr_q;

endmodule

// File: tb/tb_flash_fetch_ctrl.sv
// Self-checking bench for flash_fetch_ctrl with a behavioural flash and fetch model.
module tb_flash_fetch_ctrl;
  localparam int A = 7;
  localparam int R = 4;
`ifdef FETCH_PREFETCH_EN
  localparam bit PF_EN = 1'b1;
`else
  localparam bit PF_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        flash_ce_n, flash_oe_n, flash_we_n, flash_reset_n, flash_byte;
  logic [18:0] flash_addr;
  logic [15:0] dq_u, dq_l;
  logic [7:0]  oe_run;

  int checks   = 0;
  int failures = 0;

  // Model of the prefetch buffer as seen from the fetch stage.
  bit          pf_valid;
  logic [17:0] pf_idx;
  logic [17:0] last_idx;

  flash_fetch_ctrl_if bus();

  flash_fetch_ctrl #(.ACCESS_CYCLES(A), .RST_CYCLES(R)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .flash_ce_n     (flash_ce_n),
    .flash_oe_n     (flash_oe_n),
    .flash_we_n     (flash_we_n),
    .flash_reset_n  (flash_reset_n),
    .flash_byte     (flash_byte),
    .flash_addr     (flash_addr),
    .flash_dq_upper (dq_u),
    .flash_dq_lower (dq_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] word_u(input logic [17:0] i);
    if (i == 18'd2) return 16'h00A0;
    return i[15:0] ^ 16'h5A00 ^ {14'd0, i[17:16]};
  endfunction

  function automatic logic [15:0] word_l(input logic [17:0] i);
    if (i == 18'd2) return 16'h0093;
    return {i[7:0], i[15:8]} ^ 16'h0C3C ^ {i[17:16], 14'd0};
  endfunction

  // Flash only presents valid data once CE#/OE# have been low for the access time.
  always @(posedge clk) begin
    if (!flash_ce_n && !flash_oe_n) oe_run <= (oe_run == 8'hFF) ? oe_run : oe_run + 8'd1;
    else                            oe_run <= 8'd0;
  end
  assign dq_u = (int'(oe_run) >= A - 1) ? word_u(flash_addr[18:1]) : 16'hDEAD;
  assign dq_l = (int'(oe_run) >= A - 1) ? word_l(flash_addr[18:1]) : 16'hBEEF;

  task automatic wait_ready(output bit ok);
    int n = 0;
    while (bus.req_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    ok = (bus.req_ready === 1'b1);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL wait_ready: req_ready=%b after %0d cycles, required 1", bus.req_ready, n);
    end
  endtask

  task automatic fetch(input logic [31:0] addr, input int hold);
    bit          err, hit, ok, pf_going;
    logic [17:0] idx;
    logic [31:0] exp_instr;
    int          exp_lat, exp_ce, n, ce_seen, addr_bad, unstable;
    err       = (addr[1:0] != 2'b00) || (addr[31:20] != 12'd0);
    idx       = addr[19:2];
    hit       = PF_EN && !err && pf_valid && (pf_idx == idx);
    exp_instr = err ? 32'd0 : {word_u(idx), word_l(idx)};
    exp_lat   = (err || hit) ? 1 : A + 1;
    exp_ce    = (err || hit) ? 0 : A;

    wait_ready(ok);
    if (!ok) return;
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;

    n = 1; ce_seen = 0; addr_bad = 0;
    while (bus.rsp_valid !== 1'b1 && n < 200) begin
      if (flash_ce_n === 1'b0) begin
        ce_seen++;
        if (flash_addr !== {idx, 1'b0}) addr_bad++;
      end
      @(posedge clk); #1;
      n++;
    end

    checks++;
    if (n != exp_lat) begin
      failures++;
      $display("FAIL latency addr=%h: got %0d cycles, required %0d", addr, n, exp_lat);
    end
    checks++;
    if (ce_seen != exp_ce) begin
      failures++;
      $display("FAIL ce_cycles addr=%h: got %0d, required %0d", addr, ce_seen, exp_ce);
    end
    checks++;
    if (addr_bad != 0) begin
      failures++;
      $display("FAIL flash_addr addr=%h: %0d cycles wrong, last=%h required %h", addr, addr_bad, flash_addr, {idx, 1'b0});
    end
    checks++;
    if (bus.rsp_instr !== exp_instr || bus.rsp_err !== err) begin
      failures++;
      $display("FAIL response addr=%h: instr=%h err=%b, required instr=%h err=%b",
               addr, bus.rsp_instr, bus.rsp_err, exp_instr, err);
    end

    unstable = 0;
    for (int i = 0; i <= hold; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      if (bus.rsp_valid !== 1'b1 || bus.rsp_instr !== exp_instr || bus.rsp_err !== err ||
          bus.req_ready !== 1'b0 || dut.busy_q !== 1'b1 || flash_ce_n !== 1'b1 || flash_oe_n !== 1'b1)
        unstable++;
    end
    checks++;
    if (unstable != 0) begin
      failures++;
      $display("FAIL held_response addr=%h: %0d bad cycles of %0d (valid=%b ready=%b ce_n=%b), required 0",
               addr, unstable, hold + 1, bus.rsp_valid, bus.req_ready, flash_ce_n);
    end

    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;

    pf_going = PF_EN && !err && (idx != 18'h3FFFF);
    if (PF_EN && !err) begin
      pf_valid = pf_going;
      pf_idx   = 18'(idx + 18'd1);
    end
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== !pf_going || dut.busy_q !== pf_going) begin
      failures++;
      $display("FAIL after_handshake addr=%h: valid=%b ready=%b busy=%b, required 0 %b %b",
               addr, bus.rsp_valid, bus.req_ready, dut.busy_q, !pf_going, pf_going);
    end
    if (!err) last_idx = idx;
  endtask

  task automatic release_and_check();
    int n = 0;
    int early = 0;
    rst = 1'b0;
    do begin
      @(posedge clk); #1;
      n++;
      if (flash_reset_n !== 1'b1 && (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0)) early++;
    end while (flash_reset_n !== 1'b1 && n < 50);
    pf_valid = 1'b0;
    checks++;
    if (n != R) begin
      failures++;
      $display("FAIL flash_reset_len: got %0d cycles, required %0d", n, R);
    end
    checks++;
    if (early != 0 || bus.req_ready !== 1'b1 || dut.busy_q !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle: early=%0d ready=%b busy=%b valid=%b, required 0 1 0 0",
               early, bus.req_ready, dut.busy_q, bus.rsp_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    checks++;
    if ({flash_reset_n, flash_ce_n, flash_oe_n, flash_we_n, flash_byte} !== 5'b01111 ||
        flash_addr !== 19'd0) begin
      failures++;
      $display("FAIL reset_pins: rst_n/ce_n/oe_n/we_n/byte=%b%b%b%b%b addr=%h, required 01111 addr=00000",
               flash_reset_n, flash_ce_n, flash_oe_n, flash_we_n, flash_byte, flash_addr);
    end
    checks++;
    if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.rsp_instr !== 32'd0 ||
        bus.rsp_err !== 1'b0 || dut.busy_q !== 1'b1) begin
      failures++;
      $display("FAIL reset_bus: ready=%b valid=%b instr=%h err=%b busy=%b, required 0 0 00000000 0 1",
               bus.req_ready, bus.rsp_valid, bus.rsp_instr, bus.rsp_err, dut.busy_q);
    end
    release_and_check();
  endtask

  task automatic test_good_fetch();
    fetch(32'h0000_0008, 0);
  endtask

  task automatic test_errors();
    fetch(32'h0000_0006, 0);
    fetch(32'h0010_0000, 2);
    fetch(32'hFFFF_FFFF, 0);
  endtask

  task automatic test_backpressure();
    fetch(32'h0000_0010, 20);
  endtask

  task automatic test_reset_mid_access();
    bit ok;
    int seen_valid = 0;
    wait_ready(ok);
    if (!ok) return;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_0020;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (flash_ce_n !== 1'b1 || flash_oe_n !== 1'b1 || flash_reset_n !== 1'b0 ||
        bus.rsp_valid !== 1'b0 || dut.busy_q !== 1'b1) begin
      failures++;
      $display("FAIL abort_access: ce_n=%b oe_n=%b reset_n=%b valid=%b busy=%b, required 1 1 0 0 1",
               flash_ce_n, flash_oe_n, flash_reset_n, bus.rsp_valid, dut.busy_q);
    end
    for (int i = 0; i < 12; i++) begin
      if (i == 1) rst = 1'b0;
      if (bus.rsp_valid !== 1'b0) seen_valid++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen_valid != 0) begin
      failures++;
      $display("FAIL dropped_response: rsp_valid seen %0d cycles, required 0", seen_valid);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    release_and_check();
    fetch(32'h0000_0020, 0);
  endtask

  task automatic test_sequential();
    fetch(32'h0000_0000, 0);
    fetch(32'h0000_0004, 1);
    fetch(32'h0000_0000, 0);
    fetch(32'h0000_0040, 0);
    fetch(32'h0000_0044, 0);
    fetch(32'h0000_0003, 0);
    fetch(32'h0000_0048, 0);
  endtask

  task automatic test_boundary();
    fetch(32'h000F_FFF8, 0);
    fetch(32'h000F_FFFC, 0);
    fetch(32'h000F_FFFC, 0);
    fetch(32'h0000_0000, 0);
  endtask

  task automatic test_random();
    logic [31:0] a;
    int kind;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0)      a = {12'd0, 18'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
      else if (kind == 1) a = {12'($urandom_range(1, 4095)), 20'($urandom)};
      else if (kind <= 5) a = {12'd0, 18'(last_idx + 18'd1), 2'b00};
      else                a = {12'd0, 18'($urandom_range(0, 63)), 2'b00};
      fetch(a, $urandom_range(0, 3));
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.rsp_ready = 1'b0;
    pf_valid      = 1'b0;
    pf_idx        = '0;
    last_idx      = '0;
    @(posedge clk); #1;
    test_reset();
    test_good_fetch();
    test_errors();
    test_backpressure();
    test_reset_mid_access();
    test_sequential();
    test_boundary();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit, required completion");
    $fatal(1, "timeout");
  end
endmodule
